// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem
// Description : EX -> MEM pipeline register for the 5-stage MIPS core.
//               Registers the execute-stage results (GPR write-back, HI/LO
//               write, load/store aluop, address and store data) and applies
//               the stall vector by advancing, bubbling or holding. It also
//               holds the multiply-accumulate partial product and cycle
//               counter, which are fed back to EX across the accumulate stall.
// Ports       : clk          - pipeline clock, rising edge
//               rst          - asynchronous, active-low reset
//               stall[5:0]   - stall vector; [3] EX stop, [4] MEM stop
//               ex_*         - execute-stage results in
//               hilo_i/cnt_i - accumulate partial product / counter from EX
//               mem_*        - registered copies to MEM
//               hilo_o/cnt_o - held partial product / counter back to EX
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           stall,
    input  logic [ADDR_W-1:0]    ex_wd,
    input  logic                 ex_wreg,
    input  logic [DATA_W-1:0]    ex_wdata,
    input  logic                 ex_whilo,
    input  logic [DATA_W-1:0]    ex_hi,
    input  logic [DATA_W-1:0]    ex_lo,
    input  logic [ALUOP_W-1:0]   ex_aluop,
    input  logic [DATA_W-1:0]    ex_mem_addr,
    input  logic [DATA_W-1:0]    ex_reg2,
    input  logic [2*DATA_W-1:0]  hilo_i,
    input  logic [1:0]           cnt_i,
    output logic [ADDR_W-1:0]    mem_wd,
    output logic                 mem_wreg,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 mem_whilo,
    output logic [DATA_W-1:0]    mem_hi,
    output logic [DATA_W-1:0]    mem_lo,
    output logic [ALUOP_W-1:0]   mem_aluop,
    output logic [DATA_W-1:0]    mem_mem_addr,
    output logic [DATA_W-1:0]    mem_reg2,
    output logic [2*DATA_W-1:0]  hilo_o,
    output logic [1:0]           cnt_o
);

    localparam logic [ADDR_W-1:0]  c_NOP_REG_ADDR  = '0;
    localparam logic [ALUOP_W-1:0] c_NOP_ALUOP     = '0;
    localparam logic               c_WRITE_DISABLE = 1'b0;

    // Only the EX and MEM stop bits matter to this stage.
    logic w_ex_stop;
    logic w_mem_stop;
    logic w_bubble;
    logic w_unused_stall;

    assign w_ex_stop      = stall[3];
    assign w_mem_stop     = stall[4];
    // EX stopped but MEM running: MEM must see a NOP, not a stale repeat.
    assign w_bubble       = w_ex_stop & ~w_mem_stop;
    assign w_unused_stall = &{1'b0, stall[5], stall[2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd       <= c_NOP_REG_ADDR;
            mem_wreg     <= c_WRITE_DISABLE;
            mem_wdata    <= '0;
            mem_whilo    <= c_WRITE_DISABLE;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= c_NOP_ALUOP;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            hilo_o       <= '0;
            cnt_o        <= '0;
        end else if (!w_ex_stop) begin
            // Advance. A MEM stop without an EX stop is not a legal
            // combination and simply advances here.
            mem_wd       <= ex_wd;
            mem_wreg     <= ex_wreg;
            mem_wdata    <= ex_wdata;
            mem_whilo    <= ex_whilo;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
            hilo_o       <= '0;
            cnt_o        <= '0;
        end else if (w_bubble) begin
            // Insert a NOP toward MEM while the accumulate state is captured
            // so EX can finish the operation on its second cycle.
            mem_wd       <= c_NOP_REG_ADDR;
            mem_wreg     <= c_WRITE_DISABLE;
            mem_wdata    <= '0;
            mem_whilo    <= c_WRITE_DISABLE;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= c_NOP_ALUOP;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            hilo_o       <= hilo_i;
            cnt_o        <= cnt_i;
        end
        // Both stages stopped: every register keeps its value.
    end

endmodule
`default_nettype wire
